// File: rtl/mem0_pkg.sv
// Shared definitions for the MEM0 pipeline stage.
// Defines the bus widths, the mem_ctl bit positions, the access size codes and the FSM states.
// Also defines the EX->MEM0 and MEM0->MEM1 bus layouts and an alignment helper.
package mem0_pkg;

  localparam int EX2MEM0BusSize   = 108;
  localparam int MEM02MEM1BusSize = 77;

  // mem_ctl bit positions; bit 0 is reserved and ignored
  localparam int MC_LOAD    = 5;
  localparam int MC_STORE   = 4;
  localparam int MC_UNS     = 3;
  localparam int MC_SIZE_HI = 2;
  localparam int MC_SIZE_LO = 1;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_ACKED = 2'd2
  } mem_state_e;

  typedef struct packed {
    logic [5:0]  mem_ctl;
    logic [31:0] st_data;
    logic [31:0] exe_result;
    logic [4:0]  rd_addr;
    logic        rd_we;
    logic [31:0] pc;
  } ex_bus_t;

  typedef struct packed {
    logic        load;
    logic        uns;
    logic [1:0]  size;
    logic [1:0]  addr_lo;
    logic [31:0] exe_result;
    logic [4:0]  rd_addr;
    logic        rd_we;
    logic        ale;
    logic [31:0] pc;
  } mem1_bus_t;

  // True when the low address bits do not fit the natural alignment of the size
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
    return ((size == SIZE_HALF) && lo[0]) || ((size == SIZE_WORD) && (lo != 2'b00));
  endfunction

endpackage

// File: rtl/mem0_align.sv
// Store strobe / data lane alignment (combinational).
// Latency: 0 cycles. Backpressure: none, pure function of its inputs.
// Ports: store_i, size_i, addr_lo_i, st_data_i in; addr_lo_o (effective low address), wstrb_o, wdata_o out.
// Build option MEM0_ALIGN_CHECK_EN: when defined the raw address is used (misaligned ops are trapped
// upstream of the request); otherwise the low address bits are forced aligned to the access size.
module mem0_align
  import mem0_pkg::*;
(
  input  logic        store_i,
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] st_data_i,
  output logic [1:0]  addr_lo_o,
  output logic [3:0]  wstrb_o,
  output logic [31:0] wdata_o
);

  always_comb begin
    addr_lo_o = addr_lo_i;
`ifndef MEM0_ALIGN_CHECK_EN
    case (size_i)
      SIZE_BYTE: addr_lo_o = addr_lo_i;
      SIZE_HALF: addr_lo_o = {addr_lo_i[1], 1'b0};
      default:   addr_lo_o = 2'b00;
    endcase
`endif

    wstrb_o = 4'b1111;
    wdata_o = st_data_i;
    case (size_i)
      SIZE_BYTE: begin
        wstrb_o = 4'b0001 << addr_lo_o;
        wdata_o = {4{st_data_i[7:0]}};
      end
      SIZE_HALF: begin
        wstrb_o = 4'b0011 << {addr_lo_o[1], 1'b0};
        wdata_o = {2{st_data_i[15:0]}};
      end
      default: begin
        wstrb_o = 4'b1111;
        wdata_o = st_data_i;
      end
    endcase

    // loads never write any byte lane
    if (!store_i) begin
      wstrb_o = 4'b0000;
    end
  end

endmodule

// File: rtl/mem0.sv
// MEM0 pipeline stage: holds one EX result and issues its data memory request.
// Latency: non-memory ops complete 1 cycle after latch; memory ops complete in the cycle addr_ok is seen.
// Backpressure: valid/allowin handshake both sides; held op (and any accepted request) waits while MEM1 stalls.
// Ports: clk_i, rst_i (sync, active-high); ex2mem0_bus_i/ctl_ex_over_i/ctl_mem0_allowin_o upstream;
// mem02mem1_bus_o/ctl_mem0_over_o/ctl_mem1_allowin_i/ctl_mem0_dest_o/ctl_mem0_pc_o downstream;
// data_req_o/data_wr_o/data_size_o/data_addr_o/data_wstrb_o/data_wdata_o/data_addr_ok_i to data memory.
// Build option MEM0_ALIGN_CHECK_EN: trap misaligned half/word accesses (ale=1, no request, immediate over).
module mem0
  import mem0_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [EX2MEM0BusSize-1:0]   ex2mem0_bus_i,
  input  logic                        ctl_ex_over_i,
  output logic                        ctl_mem0_allowin_o,
  output logic [MEM02MEM1BusSize-1:0] mem02mem1_bus_o,
  output logic                        ctl_mem0_over_o,
  input  logic                        ctl_mem1_allowin_i,
  output logic [4:0]                  ctl_mem0_dest_o,
  output logic [DATA_W-1:0]           ctl_mem0_pc_o,
  output logic                        data_req_o,
  output logic                        data_wr_o,
  output logic [1:0]                  data_size_o,
  output logic [DATA_W-1:0]           data_addr_o,
  output logic [3:0]                  data_wstrb_o,
  output logic [DATA_W-1:0]           data_wdata_o,
  input  logic                        data_addr_ok_i
);

  ex_bus_t    in_bus;
  ex_bus_t    bus_q, bus_d;
  logic       valid_q, valid_d;
  mem_state_e state_q, state_d;
  mem1_bus_t  out_bus;

  logic       ld, st, ale, mem_op;
  logic       in_ld, in_st, in_ale, in_mem_op;
  logic [1:0] size;
  logic [1:0] addr_lo_eff;
  logic [3:0] wstrb;
  logic [31:0] wdata;
  logic       handoff, latch;
  logic       unused_rsvd;

  assign in_bus = ex_bus_t'(ex2mem0_bus_i);

  assign ld   = bus_q.mem_ctl[MC_LOAD];
  assign st   = bus_q.mem_ctl[MC_STORE];
  assign size = bus_q.mem_ctl[MC_SIZE_HI:MC_SIZE_LO];
  assign unused_rsvd = bus_q.mem_ctl[0];

  assign in_ld = in_bus.mem_ctl[MC_LOAD];
  assign in_st = in_bus.mem_ctl[MC_STORE];

`ifdef MEM0_ALIGN_CHECK_EN
  assign ale    = (ld | st) & misaligned(size, bus_q.exe_result[1:0]);
  assign in_ale = (in_ld | in_st) &
                  misaligned(in_bus.mem_ctl[MC_SIZE_HI:MC_SIZE_LO], in_bus.exe_result[1:0]);
`else
  assign ale    = 1'b0;
  assign in_ale = 1'b0;
`endif

  // a trapped misaligned access behaves like a non-memory op: no request, completes at once
  assign mem_op    = (ld | st) & ~ale;
  assign in_mem_op = (in_ld | in_st) & ~in_ale;

  mem0_align u_align (
    .store_i   (st),
    .size_i    (size),
    .addr_lo_i (bus_q.exe_result[1:0]),
    .st_data_i (bus_q.st_data),
    .addr_lo_o (addr_lo_eff),
    .wstrb_o   (wstrb),
    .wdata_o   (wdata)
  );

  // addr_ok only counts in REQ; in ACKED the access is already done and waits for MEM1
  assign ctl_mem0_over_o = valid_q & (~mem_op | (state_q == ST_ACKED) |
                                      ((state_q == ST_REQ) & data_addr_ok_i));
  assign data_req_o         = valid_q & mem_op & (state_q == ST_REQ);
  assign ctl_mem0_allowin_o = ~valid_q | (ctl_mem0_over_o & ctl_mem1_allowin_i);
  assign handoff            = valid_q & ctl_mem0_over_o & ctl_mem1_allowin_i;
  assign latch              = ctl_ex_over_i & ctl_mem0_allowin_o;

  always_comb begin
    valid_d = valid_q;
    bus_d   = bus_q;
    state_d = state_q;

    // request accepted but MEM1 cannot take the result: remember it so it is not reissued
    if ((state_q == ST_REQ) && data_addr_ok_i && !ctl_mem1_allowin_i) begin
      state_d = ST_ACKED;
    end
    if (handoff) begin
      valid_d = 1'b0;
      state_d = ST_IDLE;
    end
    if (latch) begin
      valid_d = 1'b1;
      bus_d   = in_bus;
      state_d = in_mem_op ? ST_REQ : ST_IDLE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      state_q <= ST_IDLE;
      bus_q   <= '0;
    end else begin
      valid_q <= valid_d;
      state_q <= state_d;
      bus_q   <= bus_d;
    end
  end

  // request fields come straight from the held register, so they stay stable until accepted
  assign data_wr_o    = st;
  assign data_size_o  = size;
  assign data_addr_o  = {bus_q.exe_result[31:2], addr_lo_eff};
  assign data_wstrb_o = wstrb;
  assign data_wdata_o = wdata;

  always_comb begin
    out_bus            = '0;
    out_bus.load       = ld;
    out_bus.uns        = bus_q.mem_ctl[MC_UNS];
    out_bus.size       = size;
    out_bus.addr_lo    = addr_lo_eff;
    out_bus.exe_result = bus_q.exe_result;
    out_bus.rd_addr    = bus_q.rd_addr;
    out_bus.rd_we      = bus_q.rd_we & ~ale;
    out_bus.ale        = ale;
    out_bus.pc         = bus_q.pc;
  end

  assign mem02mem1_bus_o = out_bus;
  assign ctl_mem0_dest_o = bus_q.rd_addr & {5{valid_q}};
  assign ctl_mem0_pc_o   = bus_q.pc;

endmodule

// File: tb/tb_mem0.sv
// Testbench for mem0: directed scenarios followed by randomized traffic, all checked against
// a transaction-level model (one held instruction plus an "already accepted by memory" flag).
// Follows the MEM0_ALIGN_CHECK_EN build option of the design.
module tb_mem0;

  typedef struct packed {
    logic        ld;
    logic        st;
    logic        uns;
    logic [1:0]  size;
    logic        rsv;
    logic [31:0] addr;
    logic [31:0] sd;
    logic [4:0]  rd;
    logic        we;
    logic [31:0] pc;
  } ins_t;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic [107:0] ex2mem0_bus_i = '0;
  logic         ctl_ex_over_i = 1'b0;
  logic         ctl_mem0_allowin_o;
  logic [76:0]  mem02mem1_bus_o;
  logic         ctl_mem0_over_o;
  logic         ctl_mem1_allowin_i = 1'b1;
  logic [4:0]   ctl_mem0_dest_o;
  logic [31:0]  ctl_mem0_pc_o;
  logic         data_req_o;
  logic         data_wr_o;
  logic [1:0]   data_size_o;
  logic [31:0]  data_addr_o;
  logic [3:0]   data_wstrb_o;
  logic [31:0]  data_wdata_o;
  logic         data_addr_ok_i = 1'b0;

  int n_chk = 0;
  int n_err = 0;
  int req_seen = 0;

  // model state
  logic m_valid = 1'b0;
  logic m_acc   = 1'b0;
  ins_t m_held  = '0;

  // last observed DUT outputs, for the directed checks
  logic        obs_req, obs_over, obs_allow;
  logic [3:0]  obs_wstrb;
  logic [31:0] obs_wdata, obs_addr;
  logic [76:0] obs_bus;
  logic [4:0]  obs_dest;

  mem0 #(.DATA_W(32)) dut (
    .clk_i              (clk_i),
    .rst_i              (rst_i),
    .ex2mem0_bus_i      (ex2mem0_bus_i),
    .ctl_ex_over_i      (ctl_ex_over_i),
    .ctl_mem0_allowin_o (ctl_mem0_allowin_o),
    .mem02mem1_bus_o    (mem02mem1_bus_o),
    .ctl_mem0_over_o    (ctl_mem0_over_o),
    .ctl_mem1_allowin_i (ctl_mem1_allowin_i),
    .ctl_mem0_dest_o    (ctl_mem0_dest_o),
    .ctl_mem0_pc_o      (ctl_mem0_pc_o),
    .data_req_o         (data_req_o),
    .data_wr_o          (data_wr_o),
    .data_size_o        (data_size_o),
    .data_addr_o        (data_addr_o),
    .data_wstrb_o       (data_wstrb_o),
    .data_wdata_o       (data_wdata_o),
    .data_addr_ok_i     (data_addr_ok_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference rules ----------------
  function automatic int unsigned nbytes(input ins_t i);
    return 32'd1 << i.size;
  endfunction

  function automatic logic f_ale(input ins_t i);
`ifdef MEM0_ALIGN_CHECK_EN
    int unsigned lo;
    lo = 32'(i.addr[1:0]);
    return (i.ld || i.st) && ((lo % nbytes(i)) != 0);
`else
    return (i.ld && i.st) && 1'b0;
`endif
  endfunction

  function automatic logic [1:0] f_lo(input ins_t i);
    int unsigned lo;
    lo = 32'(i.addr[1:0]);
`ifndef MEM0_ALIGN_CHECK_EN
    lo = lo - (lo % nbytes(i));
`endif
    return lo[1:0];
  endfunction

  function automatic logic f_memop(input ins_t i);
    return (i.ld || i.st) && !f_ale(i);
  endfunction

  function automatic logic [3:0] f_wstrb(input ins_t i);
    int unsigned mask;
    if (!i.st) return 4'b0000;
    mask = ((32'd1 << nbytes(i)) - 32'd1) << f_lo(i);
    return mask[3:0];
  endfunction

  function automatic logic [31:0] f_wdata(input ins_t i);
    if (nbytes(i) == 1) return 32'(32'(i.sd[7:0]) * 32'h0101_0101);
    if (nbytes(i) == 2) return 32'(32'(i.sd[15:0]) * 32'h0001_0001);
    return i.sd;
  endfunction

  function automatic logic [76:0] f_bus(input ins_t i);
    logic a;
    a = f_ale(i);
    return {i.ld, i.uns, i.size, f_lo(i), i.addr, i.rd, i.we & ~a, a, i.pc};
  endfunction

  function automatic logic [107:0] pack_ex(input ins_t i);
    return {i.ld, i.st, i.uns, i.size, i.rsv, i.sd, i.addr, i.rd, i.we, i.pc};
  endfunction

  function automatic ins_t mk(input logic ld, input logic st, input logic [1:0] size,
                              input logic [31:0] addr, input logic [31:0] sd,
                              input logic [4:0] rd, input logic we, input logic [31:0] pc);
    ins_t i;
    i = '0;
    i.ld = ld; i.st = st; i.size = size; i.addr = addr; i.sd = sd;
    i.rd = rd; i.we = we; i.pc = pc;
    return i;
  endfunction

  // One cycle: drive at negedge, check settled outputs against the model, advance the model.
  task automatic step(input logic exo, input ins_t ni, input logic m1a, input logic aok,
                      input logic rst);
    logic mop, e_req, e_over, e_allow;
    @(negedge clk_i);
    rst_i              = rst;
    ctl_ex_over_i      = exo;
    ex2mem0_bus_i      = pack_ex(ni);
    ctl_mem1_allowin_i = m1a;
    data_addr_ok_i     = aok;
    #1;
    mop     = m_valid && f_memop(m_held);
    e_req   = mop && !m_acc;
    e_over  = m_valid && (!mop || m_acc || aok);
    e_allow = !m_valid || (e_over && m1a);

    chk("req", data_req_o, e_req);
    chk("over", ctl_mem0_over_o, e_over);
    chk("allowin", ctl_mem0_allowin_o, e_allow);
    chk("dest", ctl_mem0_dest_o, m_valid ? m_held.rd : 5'd0);
    if (m_valid) chk("pc", ctl_mem0_pc_o, m_held.pc);
    if (e_req) begin
      chk("addr", data_addr_o, {m_held.addr[31:2], f_lo(m_held)});
      chk("size", data_size_o, m_held.size);
      chk("wr", data_wr_o, m_held.st);
      chk("wstrb", data_wstrb_o, f_wstrb(m_held));
      if (m_held.st) chk("wdata", data_wdata_o, f_wdata(m_held));
    end
    if (m_valid && e_over && m1a) chk("bus", mem02mem1_bus_o, f_bus(m_held));

    if (data_req_o) req_seen++;
    obs_req = data_req_o; obs_over = ctl_mem0_over_o; obs_allow = ctl_mem0_allowin_o;
    obs_wstrb = data_wstrb_o; obs_wdata = data_wdata_o; obs_addr = data_addr_o;
    obs_bus = mem02mem1_bus_o; obs_dest = ctl_mem0_dest_o;

    if (rst) begin
      m_valid = 1'b0;
      m_acc   = 1'b0;
    end else begin
      if (e_req && aok) m_acc = 1'b1;
      if (exo && e_allow) begin
        m_held  = ni;
        m_valid = 1'b1;
        m_acc   = 1'b0;
      end else if (m_valid && e_over && m1a) begin
        m_valid = 1'b0;
      end
    end
  endtask

  ins_t nop;
  ins_t ri;
  int   base;

  initial begin
    nop = '0;

    // reset
    step(1'b0, nop, 1'b1, 1'b0, 1'b1);
    step(1'b0, nop, 1'b1, 1'b1, 1'b1);
    step(1'b0, nop, 1'b1, 1'b1, 1'b0);
    chk("rst_allowin", obs_allow, 1'b1);
    chk("rst_req", obs_req, 1'b0);
    chk("rst_dest", obs_dest, 5'd0);

    // store byte at 0x1003, accepted on first REQ cycle
    step(1'b1, mk(1'b0, 1'b1, 2'b00, 32'h1003, 32'hAB, 5'd3, 1'b0, 32'h100), 1'b1, 1'b0, 1'b0);
    step(1'b0, nop, 1'b1, 1'b1, 1'b0);
    chk("sb_wstrb", obs_wstrb, 4'b1000);
    chk("sb_wdata", obs_wdata, 32'hABAB_ABAB);
    chk("sb_over", obs_over, 1'b1);

    // load word at 0x2000, addr_ok delayed 3 cycles
    step(1'b1, mk(1'b1, 1'b0, 2'b10, 32'h2000, 32'h0, 5'd7, 1'b1, 32'h104), 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, nop, 1'b1, 1'b0, 1'b0);
      chk("lw_req_held", obs_req, 1'b1);
      chk("lw_addr_held", obs_addr, 32'h2000);
      chk("lw_over_early", obs_over, 1'b0);
    end
    step(1'b0, nop, 1'b1, 1'b1, 1'b0);
    chk("lw_over_c4", obs_over, 1'b1);

    // store accepted while MEM1 stalls for 2 cycles: one request only
    base = req_seen;
    step(1'b1, mk(1'b0, 1'b1, 2'b10, 32'h3000, 32'hDEAD_BEEF, 5'd0, 1'b0, 32'h108), 1'b1, 1'b0, 1'b0);
    step(1'b0, nop, 1'b0, 1'b1, 1'b0);
    chk("stall_allow0", obs_allow, 1'b0);
    step(1'b0, nop, 1'b0, 1'b1, 1'b0);
    chk("stall_noreissue", obs_req, 1'b0);
    chk("stall_allow1", obs_allow, 1'b0);
    step(1'b0, nop, 1'b1, 1'b0, 1'b0);
    chk("stall_handoff", obs_allow, 1'b1);
    chk("stall_one_req", req_seen - base, 1);

    // half store at 0x1001
    step(1'b1, mk(1'b0, 1'b1, 2'b01, 32'h1001, 32'h1234, 5'd9, 1'b1, 32'h10C), 1'b1, 1'b0, 1'b0);
    step(1'b0, nop, 1'b1, 1'b1, 1'b0);
`ifdef MEM0_ALIGN_CHECK_EN
    chk("sh_noreq", obs_req, 1'b0);
    chk("sh_ale", obs_bus[32], 1'b1);
    chk("sh_we_eff", obs_bus[33], 1'b0);
`else
    chk("sh_addr", obs_addr, 32'h1000);
    chk("sh_wstrb", obs_wstrb, 4'b0011);
    chk("sh_wdata", obs_wdata, 32'h1234_1234);
`endif

    // reset during REQ
    step(1'b1, mk(1'b1, 1'b0, 2'b10, 32'h4000, 32'h0, 5'd11, 1'b1, 32'h110), 1'b1, 1'b0, 1'b0);
    step(1'b0, nop, 1'b1, 1'b0, 1'b0);
    chk("mid_req", obs_req, 1'b1);
    step(1'b0, nop, 1'b1, 1'b0, 1'b1);
    step(1'b0, nop, 1'b1, 1'b0, 1'b0);
    chk("mid_rst_req", obs_req, 1'b0);
    chk("mid_rst_valid", obs_dest, 5'd0);

    // ADD then load back to back
    step(1'b1, mk(1'b0, 1'b0, 2'b00, 32'h5, 32'h0, 5'd12, 1'b1, 32'h200), 1'b1, 1'b0, 1'b0);
    step(1'b1, mk(1'b1, 1'b0, 2'b10, 32'h6000, 32'h0, 5'd13, 1'b1, 32'h204), 1'b1, 1'b0, 1'b0);
    chk("b2b_add_over", obs_over, 1'b1);
    chk("b2b_allow", obs_allow, 1'b1);
    step(1'b0, nop, 1'b1, 1'b1, 1'b0);
    chk("b2b_ld_req", obs_req, 1'b1);

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      int kind;
      kind = $urandom_range(0, 2);
      ri = mk(kind == 1, kind == 2, 2'($urandom_range(0, 2)), $urandom, $urandom,
              5'($urandom), 1'($urandom), $urandom);
      ri.uns = 1'($urandom);
      ri.rsv = 1'($urandom);
      step($urandom_range(0, 9) < 7, ri, $urandom_range(0, 9) < 7,
           1'($urandom), $urandom_range(0, 99) == 0);
    end
    for (int n = 0; n < 4; n++) step(1'b0, nop, 1'b1, 1'b1, 1'b0);
    chk("drained", obs_allow, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
